// File: rtl/mm_pkg.sv
// Shared types and helpers for the matmul result collector.
package mm_pkg;

   localparam int SUM_MULT = 4;

   typedef enum logic {IDLE, ACTIVE} state_e;

   // Low bit index of column idx within a flattened bus of w-bit slices.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/mm_result_bank.sv
// One column of result storage: a register file with one write port and an
// asynchronous read port.
module mm_result_bank
   import mm_pkg::*;
#(
   parameter int ROW_NUM    = 32,
   parameter int SUM_WIDTH  = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [SUM_WIDTH-1:0]  wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [SUM_WIDTH-1:0]  rd_data
);

   logic [SUM_WIDTH-1:0] mem_q [ROW_NUM];
   logic [SUM_WIDTH-1:0] mem_d [ROW_NUM];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
   end

   // Contents are intentionally not reset; the completion masks gate all reads.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mm_result_collector.sv
// Collects per-column result writes into column banks and streams completed
// rows out in ascending order, one full row per valid/ready beat.
module mm_result_collector
   import mm_pkg::*;
#(
   parameter  int DATA_WIDTH     = 8,
   parameter  int ROW_NUM        = 32,
   parameter  int COL_NUM        = 32,
   localparam int SUM_WIDTH      = SUM_MULT * DATA_WIDTH,
   localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [SUM_WIDTH*COL_NUM-1:0]        row_data_in,
   input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0]   row_wraddr,
   input  logic [COL_NUM-1:0]                  row_wr_en,
   output logic [SUM_WIDTH*COL_NUM-1:0]        out_data,
   output logic [ROW_ADDR_WIDTH-1:0]           out_row,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_last,
   output logic                                busy,
   output logic                                done,
   output logic                                err
);

   localparam int                AW       = ROW_ADDR_WIDTH;
   localparam logic [AW:0]       ROW_END  = (AW+1)'(ROW_NUM);
   localparam logic [AW-1:0]     LAST_ROW = AW'(ROW_NUM - 1);

   state_e                                 state_q, state_d;
   logic [ROW_NUM-1:0][COL_NUM-1:0]        mask_q, mask_d;
   logic [AW:0]                            rd_ptr_q, rd_ptr_d;
   logic [COL_NUM-1:0]                     wr_en_q, wr_en_d;
   logic [COL_NUM-1:0][AW-1:0]             wr_addr_q, wr_addr_d;
   logic [COL_NUM-1:0][SUM_WIDTH-1:0]      wr_data_q, wr_data_d;
   logic [COL_NUM-1:0][SUM_WIDTH-1:0]      bank_rd;
   logic [COL_NUM-1:0]                     fault;
   logic [COL_NUM-1:0][SUM_WIDTH-1:0]      out_data_q, out_data_d;
   logic [AW-1:0]                          out_row_q, out_row_d;
   logic                                   out_valid_q, out_valid_d;
   logic                                   out_last_q, out_last_d;
   logic                                   done_q, done_d;
   logic                                   err_q, err_d;
   logic                                   hs, load;

   // Writes are checked on entry, then registered one cycle before landing in
   // the bank and mask, so a row becomes visible two edges after its last write.
   for (genvar i = 0; i < COL_NUM; i++) begin : g_col
      logic [AW-1:0] addr;
      assign addr         = row_wraddr[slice_lo(i, AW) +: AW];
      assign fault[i]     = row_wr_en[i] && (state_q != ACTIVE ||
                            {1'b0, addr} >= ROW_END || {1'b0, addr} < rd_ptr_q);
      assign wr_en_d[i]   = row_wr_en[i] && !fault[i];
      assign wr_addr_d[i] = addr;
      assign wr_data_d[i] = row_data_in[slice_lo(i, SUM_WIDTH) +: SUM_WIDTH];

      mm_result_bank #(
         .ROW_NUM    (ROW_NUM),
         .SUM_WIDTH  (SUM_WIDTH),
         .ADDR_WIDTH (AW)
      ) u_bank (
         .clk     (clk),
         .wr_en   (wr_en_q[i]),
         .wr_addr (wr_addr_q[i]),
         .wr_data (wr_data_q[i]),
         .rd_addr (rd_ptr_q[AW-1:0]),
         .rd_data (bank_rd[i])
      );
   end

   assign hs   = out_valid_q && out_ready;
   assign load = (state_q == ACTIVE) && (rd_ptr_q < ROW_END) &&
                 (&mask_q[rd_ptr_q[AW-1:0]]) && (!out_valid_q || out_ready);

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      rd_ptr_d    = rd_ptr_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      err_d       = err_q || (|fault);
      for (int i = 0; i < COL_NUM; i++) begin
         if (wr_en_q[i]) mask_d[wr_addr_q[i]][i] = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = ACTIVE;
               mask_d   = '0;
               rd_ptr_d = '0;
               err_d    = 1'b0;
            end
         end
         ACTIVE: begin
            if (hs) out_valid_d = 1'b0;
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = bank_rd;
               out_row_d   = rd_ptr_q[AW-1:0];
               out_last_d  = (rd_ptr_q[AW-1:0] == LAST_ROW);
               rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (hs && out_last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         rd_ptr_q    <= '0;
         wr_en_q     <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_row   = out_row_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == ACTIVE);
   assign done      = done_q;
   assign err       = err_q;

endmodule
